pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, SHALL set the number of return-stack entries (power of two, 2..16).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run  input  1  start request, sampled only in HALT.
REQ-005 pc_addr  input  8  current program-counter value.
REQ-006 pc_load  output  1  program-counter load strobe; 0 means the counter increments at this edge.
REQ-007 pc_data  output  8  program-counter load value.
REQ-008 imem_req  output  1  instruction-memory read request; address is pc_addr.
REQ-009 imem_ack  input  1  read-data-valid strobe for the current request.
REQ-010 imem_rdata  input  8  instruction-memory read data.
REQ-011 zero_flag  input  1  datapath zero flag, sampled in BRANCH.
REQ-012 issue_valid  output  1  datapath-op offer.
REQ-013 issue_op  output  8  opcode offered to the datapath.
REQ-014 issue_ready  input  1  datapath accepts the offered opcode.
REQ-015 halted  output  1  high in state HALT.
REQ-016 fault  output  1  sticky return-stack overflow/underflow flag.

Function
REQ-017 Encoding on op[7:4] SHALL be: 0 NOP, 1 JMP, 2 JZ, 3 CALL, 4 RET, F HALT, all others datapath ops; JMP, JZ and CALL SHALL take one operand byte (target).
REQ-018 States SHALL be HALT, FETCH, DECODE, OPERAND, BRANCH, ISSUE.
REQ-019 Default PC hold: in every cycle not granted an increment or jump, pc_load=1 and pc_data=pc_addr.
REQ-020 FETCH: imem_req=1 and PC held; on imem_ack=1, opcode <- imem_rdata, pc_load=0 in that cycle, next DECODE.
REQ-021 DECODE, from opcode: NOP -> FETCH; HALT -> HALT; JMP/JZ/CALL -> OPERAND; datapath op -> ISSUE.
REQ-022 DECODE, RET: if the stack is non-empty, pc_load=1, pc_data=top entry, pop, next FETCH; if the stack is empty, fault <- 1, next HALT.
REQ-023 OPERAND: imem_req=1 and PC held; on imem_ack=1, target <- imem_rdata, pc_load=0, next BRANCH.
REQ-024 BRANCH, JMP: pc_load=1, pc_data=target.
REQ-025 BRANCH, JZ: if zero_flag=1, load target; otherwise hold.
REQ-026 BRANCH, CALL: if the stack is not full, push pc_addr (the return address, already past the operand), then load target; if full, fault <- 1, next HALT with no push and no load.
REQ-027 BRANCH SHALL go to FETCH in all cases other than the fault in REQ-026.
REQ-028 ISSUE: issue_valid=1, issue_op=opcode, PC held; on issue_ready=1, next FETCH; issue_op SHALL be stable while issue_valid=1.
REQ-029 HALT: halted=1 and PC held; run=1 -> FETCH with the PC unchanged; run SHALL be ignored in all other states.
REQ-030 imem_ack outside FETCH/OPERAND and issue_ready outside ISSUE SHALL be ignored.
REQ-031 Stack is LIFO; pointer width is clog2(STACK_DEPTH)+1; the return stack never wraps.
REQ-032 fault SHALL clear only on reset; run from HALT with fault=1 is permitted.
REQ-033 pc_load, pc_data, imem_req, issue_valid, issue_op and halted SHALL be combinational decodes of the state and internal registers only; there is no input-to-output path except imem_ack/issue_ready gating pc_load.

Reset
REQ-034 On rst=1, the block SHALL immediately enter state HALT and empty the stack.
REQ-035 During and after reset: fault=0, opcode=0, target=0; outputs halted=1, pc_load=1, pc_data=pc_addr, imem_req=0, issue_valid=0, issue_op=0.
REQ-036 Reset mid-fetch or mid-issue SHALL abandon the transaction with no push or pop.

Structure
REQ-037 A shared package SHALL hold the state enum, the opcode field constants (NOP/JMP/JZ/CALL/RET/HALT) and an is_two_byte function.
REQ-038 The return stack SHALL be sub-module ret_stack (push, pop, full, empty, top), instantiated once.

Verification
REQ-039 Reset, run=1, memory {0x00,0x00} with 1-cycle ack -> PC 0->1->2; each increment coincides with an ack cycle.
REQ-040 JMP: memory[2]=0x10, [3]=0x40 -> PC reaches 4, then loads 0x40; next fetch address is 0x40.
REQ-041 JZ 0x20 with zero_flag=0 -> PC continues at op+2; with zero_flag=1 -> PC=0x20.
REQ-042 CALL 0x80 at 0x05, RET at 0x80 -> push 0x07, PC=0x80, then PC=0x07, stack empty.
REQ-043 STACK_DEPTH+1 nested CALLs -> fault=1, halted=1, PC holds; RET with empty stack -> fault=1, HALT.
REQ-044 Datapath op 0x5A with issue_ready delayed 3 cycles -> issue_valid held 4 cycles, issue_op=0x5A, PC constant; rst asserted mid-ISSUE -> issue_valid=0 immediately, halted=1.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: FSM states, opcode field values and
// the operand-length helper.
package pc_sequencer_pkg;

  localparam int PC_W = 8;

  typedef enum logic [2:0] {
    ST_HALT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_BRANCH  = 3'd4,
    ST_ISSUE   = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_CALL = 4'h3;
  localparam logic [3:0] OP_RET  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  // JMP, JZ and CALL carry a one-byte target after the opcode.
  function automatic logic is_two_byte(input logic [7:0] op);
    return (op[7:4] == OP_JMP) || (op[7:4] == OP_JZ) || (op[7:4] == OP_CALL);
  endfunction

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO; push is ignored when full and pop when empty, so the
// pointer never wraps.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_top
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] PTR_FULL = (AW+1)'(DEPTH);

  logic [AW:0]  r_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;
  logic [AW:0]  w_top_idx;

  assign o_full    = (r_ptr == PTR_FULL);
  assign o_empty   = (r_ptr == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_top_idx = r_ptr - PTR_ONE;
  assign o_top     = r_mem[w_top_idx[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + PTR_ONE;
    end else if (w_do_pop) begin
      r_ptr <= r_ptr - PTR_ONE;
    end
  end

  // Entries need no reset: they are only read while the pointer says valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetches opcodes/operands, steers the external PC
// (hold, increment or load), manages calls/returns and offers datapath ops.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_run,
  input  logic [PC_W-1:0] i_pc_addr,
  output logic            o_pc_load,
  output logic [PC_W-1:0] o_pc_data,
  output logic            o_imem_req,
  input  logic            i_imem_ack,
  input  logic [7:0]      i_imem_rdata,
  input  logic            i_zero_flag,
  output logic            o_issue_valid,
  output logic [7:0]      o_issue_op,
  input  logic            i_issue_ready,
  output logic            o_halted,
  output logic            o_fault
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [7:0]      r_opcode;
  logic [7:0]      w_opcode_nxt;
  logic [PC_W-1:0] r_target;
  logic [PC_W-1:0] w_target_nxt;
  logic            r_fault;
  logic            w_fault_nxt;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [PC_W-1:0] w_top;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_ret_stack (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_pc_addr),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_top   (w_top)
  );

  assign o_issue_op = r_opcode;
  assign o_fault    = r_fault;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_HALT;
      r_opcode <= '0;
      r_target <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_opcode <= w_opcode_nxt;
      r_target <= w_target_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_opcode_nxt  = r_opcode;
    w_target_nxt  = r_target;
    w_fault_nxt   = r_fault;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    o_pc_load     = 1'b1;
    o_pc_data     = i_pc_addr;
    o_imem_req    = 1'b0;
    o_issue_valid = 1'b0;
    o_halted      = 1'b0;

    case (r_state)
      ST_HALT: begin
        o_halted = 1'b1;
        if (i_run) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_pc_load    = 1'b0;
          w_opcode_nxt = i_imem_rdata;
          w_state_nxt  = ST_DECODE;
        end
      end

      ST_DECODE: begin
        case (r_opcode[7:4])
          OP_NOP:  w_state_nxt = ST_FETCH;
          OP_HALT: w_state_nxt = ST_HALT;
          OP_RET: begin
            if (!w_empty) begin
              o_pc_data   = w_top;
              w_pop       = 1'b1;
              w_state_nxt = ST_FETCH;
            end else begin
              w_fault_nxt = 1'b1;
              w_state_nxt = ST_HALT;
            end
          end
          default: begin
            w_state_nxt = is_two_byte(r_opcode) ? ST_OPERAND : ST_ISSUE;
          end
        endcase
      end

      ST_OPERAND: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_pc_load    = 1'b0;
          w_target_nxt = i_imem_rdata;
          w_state_nxt  = ST_BRANCH;
        end
      end

      ST_BRANCH: begin
        // PC already points past the operand, so it is the return address.
        w_state_nxt = ST_FETCH;
        case (r_opcode[7:4])
          OP_JMP: o_pc_data = r_target;
          OP_JZ: begin
            if (i_zero_flag) begin
              o_pc_data = r_target;
            end
          end
          OP_CALL: begin
            if (!w_full) begin
              w_push    = 1'b1;
              o_pc_data = r_target;
            end else begin
              w_fault_nxt = 1'b1;
              w_state_nxt = ST_HALT;
            end
          end
          default: w_state_nxt = ST_FETCH;
        endcase
      end

      ST_ISSUE: begin
        o_issue_valid = 1'b1;
        if (i_issue_ready) begin
          w_state_nxt = ST_FETCH;
        end
      end

      default: w_state_nxt = ST_HALT;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: an instruction-level interpreter predicts the
// memory read addresses, issued ops and final PC/fault for each program.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [7:0] pc_addr = 8'h00;
  logic       pc_load;
  logic [7:0] pc_data;
  logic       imem_req;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_rdata = 8'h00;
  logic       zero_flag = 1'b0;
  logic       issue_valid;
  logic [7:0] issue_op;
  logic       issue_ready = 1'b0;
  logic       halted;
  logic       fault;

  pc_sequencer #(.STACK_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_run         (run),
    .i_pc_addr     (pc_addr),
    .o_pc_load     (pc_load),
    .o_pc_data     (pc_data),
    .o_imem_req    (imem_req),
    .i_imem_ack    (imem_ack),
    .i_imem_rdata  (imem_rdata),
    .i_zero_flag   (zero_flag),
    .o_issue_valid (issue_valid),
    .o_issue_op    (issue_op),
    .i_issue_ready (issue_ready),
    .o_halted      (halted),
    .o_fault       (fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_reads [$];
  logic [7:0] exp_issue [$];
  logic [7:0] m_pc;
  bit         m_fault, m_halt, m_trunc;

  int  ack_lat = -1, rdy_lat = -1;
  bit  rdy_block = 0, spur = 1;
  int  ack_cnt, rdy_cnt;
  int  valid_cnt, n_inc, n_acks;
  bit  prev_valid;
  logic [7:0] prev_op, prev_pc;
  logic       s_load;
  logic [7:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int new_ack_lat();
    return (ack_lat < 0) ? int'($urandom_range(0, 2)) : ack_lat;
  endfunction

  function automatic int new_rdy_lat();
    return (rdy_lat < 0) ? int'($urandom_range(0, 3)) : rdy_lat;
  endfunction

  // Instruction-set interpreter: one loop iteration per executed instruction.
  task automatic model(input logic [7:0] start, input bit zf, input int max_instr);
    logic [7:0] pc, op, tgt;
    logic [7:0] stk [16];
    int sp = 0;
    exp_reads.delete();
    exp_issue.delete();
    pc = start;
    m_fault = 0; m_halt = 0; m_trunc = 1;
    for (int n = 0; n < max_instr; n++) begin
      op = mem[pc];
      exp_reads.push_back(pc);
      pc = pc + 8'd1;
      if (op[7:4] == 4'h1 || op[7:4] == 4'h2 || op[7:4] == 4'h3) begin
        exp_reads.push_back(pc);
        tgt = mem[pc];
        pc = pc + 8'd1;
        if (op[7:4] == 4'h1) pc = tgt;
        else if (op[7:4] == 4'h2) begin
          if (zf) pc = tgt;
        end else if (sp == DEPTH) begin
          m_fault = 1; m_halt = 1;
        end else begin
          stk[sp] = pc; sp++; pc = tgt;
        end
      end else if (op[7:4] == 4'h4) begin
        if (sp == 0) begin
          m_fault = 1; m_halt = 1;
        end else begin
          sp--; pc = stk[sp];
        end
      end else if (op[7:4] == 4'hF) begin
        m_halt = 1;
      end else if (op[7:4] != 4'h0) begin
        exp_issue.push_back(op);
      end
      if (m_halt) begin
        m_trunc = 0;
        break;
      end
    end
    m_pc = pc;
  endtask

  task automatic drive();
    if (imem_req) begin
      imem_ack = (ack_cnt == 0);
      if (ack_cnt > 0) ack_cnt--;
      imem_rdata = mem[pc_addr];
    end else begin
      imem_ack = spur && ($urandom_range(0, 3) == 0);
      imem_rdata = 8'($urandom);
    end
    if (issue_valid) begin
      issue_ready = !rdy_block && (rdy_cnt == 0);
      if (!issue_ready && rdy_cnt > 0) rdy_cnt--;
    end else begin
      issue_ready = spur && ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic monitor();
    if (!pc_load) n_inc++;
    if (imem_req && imem_ack) begin
      n_acks++;
      chk("inc_on_ack", pc_load, 1'b0);
      if (exp_reads.size() == 0) chk("extra_read", 1, 0);
      else chk("read_addr", pc_addr, exp_reads.pop_front());
      ack_cnt = new_ack_lat();
    end
    if (issue_valid) begin
      valid_cnt++;
      if (prev_valid) begin
        chk("op_stable", issue_op, prev_op);
        chk("pc_stable_issue", pc_addr, prev_pc);
      end
      if (issue_ready) begin
        if (exp_issue.size() == 0) chk("extra_issue", 1, 0);
        else chk("issue_op", issue_op, exp_issue.pop_front());
        rdy_cnt = new_rdy_lat();
        prev_valid = 0;
      end else begin
        prev_valid = 1; prev_op = issue_op; prev_pc = pc_addr;
      end
    end else begin
      prev_valid = 0;
    end
  endtask

  task automatic tick();
    drive();
    #1;
    monitor();
    s_load = pc_load;
    s_data = pc_data;
    @(posedge clk);
    #1;
    pc_addr = s_load ? s_data : pc_addr + 8'd1;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] start);
    rst = 1; run = 0; imem_ack = 0; issue_ready = 0;
    #1;
    chk("rst_halted", halted, 1'b1);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_issue_valid", issue_valid, 1'b0);
    chk("rst_issue_op", issue_op, 8'h00);
    chk("rst_pc_load", pc_load, 1'b1);
    chk("rst_pc_data", pc_data, pc_addr);
    chk("rst_fault", fault, 1'b0);
    @(posedge clk);
    #1;
    pc_addr = start;
    @(negedge clk);
    rst = 0;
    ack_cnt = new_ack_lat();
    rdy_cnt = new_rdy_lat();
    valid_cnt = 0; n_inc = 0; n_acks = 0; prev_valid = 0;
  endtask

  task automatic run_prog(input logic [7:0] start, input bit zf, input string name);
    bit done = 0;
    do_reset(start);
    zero_flag = zf;
    model(start, zf, 60);
    run = 1;
    tick();
    run = 0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_reads.size() == 0 && (m_trunc || halted)) begin
        done = 1;
        break;
      end
      tick();
    end
    chk({name, "_timeout"}, done, 1'b1);
    if (!m_trunc) begin
      chk({name, "_halted"}, halted, 1'b1);
      chk({name, "_pc"}, pc_addr, m_pc);
      chk({name, "_fault"}, fault, m_fault);
      chk({name, "_issue_left"}, exp_issue.size(), 0);
      chk({name, "_inc_eq_acks"}, n_inc, n_acks);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    int r = $urandom_range(0, 15);
    case (r)
      0:       return {4'h0, 4'($urandom)};
      1:       return 8'h10;
      2:       return 8'h20;
      3, 4:    return 8'h30;
      5, 6:    return 8'h40;
      7:       return 8'hF0;
      default: return {4'($urandom_range(5, 14)), 4'($urandom)};
    endcase
  endfunction

  initial begin
    @(negedge clk);

    // Straight-line NOPs: one increment per acknowledged read.
    foreach (mem[i]) mem[i] = 8'h00;
    mem[2] = 8'hF0;
    ack_lat = 0; rdy_lat = 0;
    run_prog(8'h00, 0, "nop_seq");
    chk("nop_seq_incs", n_inc, 3);

    // Run from HALT with a different latency mix.
    ack_lat = 2;
    run_prog(8'h00, 0, "nop_slow_ack");
    ack_lat = -1; rdy_lat = -1;

    // JMP 0x40 after two NOPs.
    foreach (mem[i]) mem[i] = 8'h00;
    mem[2] = 8'h10; mem[3] = 8'h40; mem[8'h40] = 8'hF0;
    run_prog(8'h00, 0, "jmp");

    // JZ 0x20 not-taken and taken.
    foreach (mem[i]) mem[i] = 8'hF0;
    mem[0] = 8'h20; mem[1] = 8'h20;
    run_prog(8'h00, 0, "jz_not_taken");
    chk("jz_nt_pc_direct", pc_addr, 8'h03);
    run_prog(8'h00, 1, "jz_taken");
    chk("jz_t_pc_direct", pc_addr, 8'h21);

    // CALL 0x80 at 0x05, RET at 0x80, then a RET that finds the stack empty.
    foreach (mem[i]) mem[i] = 8'h00;
    mem[5] = 8'h30; mem[6] = 8'h80; mem[8'h80] = 8'h40; mem[7] = 8'h40;
    run_prog(8'h00, 0, "call_ret");
    chk("call_ret_pc_direct", pc_addr, 8'h08);

    // Nested CALLs one deeper than the stack.
    foreach (mem[i]) mem[i] = 8'hF0;
    for (int k = 0; k <= DEPTH; k++) begin
      mem[2*k] = 8'h30; mem[2*k+1] = 8'(2*k + 2);
    end
    run_prog(8'h00, 0, "overflow");
    chk("overflow_fault", fault, 1'b1);

    // RET on empty stack, then restart while faulted.
    foreach (mem[i]) mem[i] = 8'hF0;
    mem[0] = 8'h40;
    run_prog(8'h00, 0, "underflow");
    exp_reads.push_back(8'h01);
    run = 1; tick(); run = 0;
    for (int c = 0; c < 20; c++) tick();
    chk("rerun_halted", halted, 1'b1);
    chk("rerun_fault_sticky", fault, 1'b1);
    chk("rerun_pc", pc_addr, 8'h02);

    // Datapath op with ready delayed three cycles.
    foreach (mem[i]) mem[i] = 8'hF0;
    mem[0] = 8'h5A;
    rdy_lat = 3;
    run_prog(8'h00, 0, "issue");
    chk("issue_valid_cycles", valid_cnt, 4);
    rdy_lat = -1;

    // Reset while an op is being offered.
    rdy_block = 1;
    do_reset(8'h00);
    model(8'h00, 0, 60);
    run = 1; tick(); run = 0;
    for (int c = 0; c < 20 && !issue_valid; c++) tick();
    chk("issue_reached", issue_valid, 1'b1);
    tick(); tick();
    do_reset(8'h00);
    rdy_block = 0;

    // Random programs.
    for (int p = 0; p < 40; p++) begin
      foreach (mem[i]) mem[i] = rand_byte();
      run_prog(8'($urandom_range(0, 255)), 1'($urandom), "rand");
      if (m_trunc) do_reset(8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
